// File: rtl/conversor_bin_bcd.sv
// Sequential binary-to-BCD converter (shift-and-add-3) with valid/ready on both sides.
// Sits behind the 4x4 multiplier and feeds the display decoder with packed BCD digits.
module conversor_bin_bcd #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int SCR_W = 4 * DIGITS;

    // Every representable input must fit in the available decimal digits.
    if (10 ** DIGITS <= 2 ** WIDTH - 1) begin : g_digits_check
        $error("conversor_bin_bcd: DIGITS too small for WIDTH");
    end

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sh_q, sh_d;
    logic [SCR_W-1:0]   scr_q, scr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SCR_W-1:0]   bcd_q, bcd_d;

    logic [SCR_W-1:0]   scr_adj;
    logic [SCR_W-1:0]   scr_shift;
    logic [WIDTH-1:0]   sh_shift;

    // One double-dabble step: correct every digit >= 5, then shift {scr,sh} left.
    always_comb begin
        scr_adj = scr_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (scr_q[4*i +: 4] >= 4'd5) begin
                scr_adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
            end
        end
        scr_shift = {scr_adj[SCR_W-2:0], sh_q[WIDTH-1]};
        sh_shift  = {sh_q[WIDTH-2:0], 1'b0};
    end

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        scr_d   = scr_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sh_d    = bin;
                    scr_d   = '0;
                    cnt_d   = CNT_W'(WIDTH);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sh_d  = sh_shift;
                scr_d = scr_shift;
                cnt_d = cnt_q - CNT_W'(1);
                // The last iteration publishes its shifted scratch straight to bcd.
                if (cnt_q == CNT_W'(1)) begin
                    bcd_d   = scr_shift;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sh_q    <= '0;
            scr_q   <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            scr_q   <= scr_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == SHIFT) || (state_q == DONE);
    assign bcd       = bcd_q;

endmodule

// File: tb/tb_conversor_bin_bcd.sv
// Directed self-checking bench for conversor_bin_bcd: reset, boundaries, backpressure,
// input blocking while busy, and a back-to-back sweep of every 4x4 product.
module tb_conversor_bin_bcd;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  bin;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] bcd;
    logic        busy;

    int assert_count = 0;
    int fail_count   = 0;

    conversor_bin_bcd #(
        .WIDTH  (8),
        .DIGITS (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bcd       (bcd),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assert_count++;
        if (got !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Decimal reference built from division, independent of the shift-add-3 method.
    function automatic logic [11:0] toBcd(input int value);
        toBcd = {4'(value / 100), 4'((value / 10) % 10), 4'(value % 10)};
    endfunction

    // Waits (bounded) for in_ready, presents one value for exactly the accepting edge.
    task automatic applyStimulus(input logic [7:0] value);
        int guard;
        guard = 0;
        while (!in_ready && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("ready_before_accept", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        bin      = value;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Counts edges after acceptance until out_valid is seen; called right after applyStimulus.
    task automatic waitResult(output int lat);
        lat = 0;
        while (!out_valid && lat < 30) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic convertOne(input string tag, input logic [7:0] value, input logic [11:0] exp);
        int lat;
        applyStimulus(value);
        waitResult(lat);
        checkOutput({tag, "_latency"}, 32'(lat), 32'd8);
        checkOutput({tag, "_bcd"}, 32'(bcd), 32'(exp));
        @(negedge clk);
    endtask

    initial begin
        int lat;
        int seen;
        int gap;
        int cycle;
        int last_accept;
        int n_accept;
        int n_result;
        logic [11:0] expq[$];

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        bin       = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_bcd", 32'(bcd), 32'h000);

        // Reset in the middle of a conversion of 200.
        applyStimulus(8'd200);
        repeat (3) @(negedge clk);
        checkOutput("midshift_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_bcd", 32'(bcd), 32'h000);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checkOutput("midrst_no_valid", 32'(seen), 32'd0);
        checkOutput("midrst_bcd_after", 32'(bcd), 32'h000);

        // Multiplier maximum 15x15.
        out_ready = 1'b1;
        applyStimulus(8'd225);
        waitResult(lat);
        checkOutput("max_latency", 32'(lat), 32'd8);
        checkOutput("max_bcd", 32'(bcd), 32'h225);
        checkOutput("max_out_valid", 32'(out_valid), 32'd1);
        checkOutput("max_in_ready_low", 32'(in_ready), 32'd0);
        @(negedge clk);
        checkOutput("max_busy_after", 32'(busy), 32'd0);
        checkOutput("max_idle_after", 32'(in_ready), 32'd1);
        checkOutput("max_bcd_hold", 32'(bcd), 32'h225);

        convertOne("b0", 8'd0, 12'h000);
        convertOne("b9", 8'd9, 12'h009);
        convertOne("b10", 8'd10, 12'h010);
        convertOne("b99", 8'd99, 12'h099);
        convertOne("b100", 8'd100, 12'h100);
        convertOne("b255", 8'd255, 12'h255);

        // Backpressure: consumer stalls 6 cycles.
        out_ready = 1'b0;
        applyStimulus(8'd144);
        waitResult(lat);
        checkOutput("bp_latency", 32'(lat), 32'd8);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
            checkOutput("bp_bcd", 32'(bcd), 32'h144);
            checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_release_idle", 32'(in_ready), 32'd1);
        checkOutput("bp_release_valid", 32'(out_valid), 32'd0);

        // in_valid held with a different value throughout SHIFT and DONE.
        applyStimulus(8'd36);
        in_valid = 1'b1;
        bin      = 8'd81;
        waitResult(lat);
        checkOutput("ign_latency", 32'(lat), 32'd8);
        checkOutput("ign_bcd", 32'(bcd), 32'h036);
        gap = 0;
        @(negedge clk);
        gap++;
        while (!out_valid && gap < 30) begin
            @(negedge clk);
            gap++;
        end
        in_valid = 1'b0;
        checkOutput("ign_second_gap", 32'(gap), 32'd10);
        checkOutput("ign_second_bcd", 32'(bcd), 32'h081);
        @(negedge clk);

        // Back-to-back sweep of every A*B with both handshakes held high.
        in_valid    = 1'b1;
        out_ready   = 1'b1;
        cycle       = 0;
        last_accept = -1;
        n_accept    = 0;
        n_result    = 0;
        while (n_result < 256 && cycle < 4000) begin
            if (out_valid) begin
                if (expq.size() > 0) begin
                    checkOutput("sweep_bcd", 32'(bcd), 32'(expq.pop_front()));
                end else begin
                    checkOutput("sweep_unexpected", 32'd1, 32'd0);
                end
                n_result++;
            end
            if (in_ready && n_accept < 256) begin
                bin = 8'((n_accept / 16) * (n_accept % 16));
                expq.push_back(toBcd((n_accept / 16) * (n_accept % 16)));
                if (last_accept >= 0) begin
                    checkOutput("sweep_spacing", 32'(cycle - last_accept), 32'd10);
                end
                last_accept = cycle;
                n_accept++;
            end
            @(negedge clk);
            cycle++;
        end
        in_valid = 1'b0;
        checkOutput("sweep_results", 32'(n_result), 32'd256);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule

// File: doc/conversor_bin_bcd.md
# conversor_bin_bcd

Sequential binary-to-BCD converter placed directly downstream of the 4x4 combinational multiplier. It captures the 8-bit product, converts it to three packed BCD digits with a shift-and-add-3 (double-dabble) iteration, and presents the digits to the display/decoder stage. A valid/ready handshake runs on both sides.

## Interface
- WIDTH, 8, binary input width. Matches the multiplier product P.
- DIGITS, 3, BCD digits produced. Must satisfy 10^DIGITS > 2^WIDTH - 1.
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  bin holds a product to convert.
- in_ready  output  1  block can accept; high only in IDLE.
- bin  input  WIDTH  unsigned binary value (multiplier P).
- out_valid  output  1  bcd holds a completed result; high only in DONE.
- out_ready  input  1  consumer accepts bcd.
- bcd  output  4*DIGITS  packed BCD. [3:0] is units, [7:4] is tens, [11:8] is hundreds.
- busy  output  1  high in SHIFT or DONE.

## Operation
- The FSM has three states: IDLE, SHIFT and DONE.
- IDLE:
  - in_ready=1.
  - When in_valid=1 at an edge, load shift register sh=bin, clear the scratch BCD register scr=0, load counter cnt=WIDTH, and go to SHIFT.
- SHIFT, one iteration per cycle:
  - Every 4-bit digit of scr that is >=5 gets +3, all digits in parallel.
  - Then {scr,sh} shifts left 1 bit. The MSB of sh enters the LSB of scr.
  - cnt decrements.
  - When the iteration that takes cnt from 1 to 0 completes, copy the shifted scr into bcd and go to DONE.
- DONE:
  - out_valid=1 and bcd is stable.
  - When out_ready=1 at an edge, go to IDLE.
- bcd is a dedicated output register. It updates only on entry to DONE and holds the last result until the next completion, including through IDLE.
- in_valid is ignored outside IDLE (in_ready=0). Changes on bin after acceptance have no effect.
- Arithmetic: unsigned only. Each digit is always 0..9 at the output. No overflow is possible when the DIGITS constraint holds.
- Width rules: scr is 4*DIGITS bits and cnt is ceil(log2(WIDTH+1)) bits.
- Reset (rst_n=0), asynchronous and at any time, including mid-SHIFT:
  - state=IDLE, sh=0, scr=0, cnt=0, bcd=0.
  - In-flight conversion is discarded. No partial result appears on bcd.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, bcd=0. The first acceptance can happen on the first edge after rst_n deasserts.
- Edge numbering: acceptance at edge E0. SHIFT iterations occupy edges E1..EWIDTH (E1..E8 by default).
- out_valid=1 and bcd is valid immediately after edge EWIDTH. Latency from acceptance is WIDTH cycles.
- With out_ready held at 1:
  - DONE lasts exactly 1 cycle.
  - IDLE is re-entered after EWIDTH+1.
  - The next acceptance is at EWIDTH+2, giving a throughput of one conversion per WIDTH+2 cycles (10 by default).
- Backpressure: DONE, out_valid and bcd hold indefinitely while out_ready=0.
- in_ready and out_valid are never high in the same cycle.
- out_ready is only sampled in DONE; out_ready=1 in other states has no effect.

## Test plan
- Reset: hold rst_n=0, then release. Required: in_ready=1, out_valid=0, busy=0, bcd=12'h000. Then pulse rst_n=0 for 3 cycles mid-SHIFT of bin=8'd200. Required: immediate return to IDLE, bcd stays 12'h000, out_valid never asserts.
- Multiplier maximum: bin=8'd225 (15x15), out_ready=1. Required: out_valid rises exactly 8 cycles after acceptance with bcd=12'h225, busy low again 1 cycle later.
- Boundaries: convert 0, 9, 10, 99, 100 and 255. Required: bcd=12'h000, 12'h009, 12'h010, 12'h099, 12'h100, 12'h255.
- Backpressure: bin=8'd144, out_ready=0 for 6 cycles after out_valid, then 1. Required:
  - out_valid and bcd=12'h144 stable for all 6 cycles.
  - IDLE entered on the edge where out_ready=1.
- Input ignored while busy: accept bin=8'd36, then drive in_valid=1 with bin=8'd81 throughout SHIFT and DONE. Required:
  - Result is 12'h036.
  - 81 is accepted on the first IDLE edge and produces 12'h081 afterwards.
- Throughput and exhaustive sweep: in_valid=1 and out_ready=1 continuously. Feed all products A*B for A,B in 0..15. Required:
  - Acceptances exactly 10 cycles apart.
  - Every result equals the decimal value of A*B.
